// File: rtl/edge_det_pkg.sv
// Shared types and mode encodings for the multi-channel edge detector.
package edge_det_pkg;

    typedef logic [1:0] edge_mode_t;

    localparam edge_mode_t MODE_OFF  = 2'b00;
    localparam edge_mode_t MODE_RISE = 2'b01;
    localparam edge_mode_t MODE_FALL = 2'b10;
    localparam edge_mode_t MODE_BOTH = 2'b11;

    // True when a detected edge is one the channel's mode asks to report.
    function automatic logic qualify(edge_mode_t mode, logic rise, logic fall);
        return (rise && (mode == MODE_RISE || mode == MODE_BOTH)) ||
               (fall && (mode == MODE_FALL || mode == MODE_BOTH));
    endfunction

endpackage

// File: rtl/multi_edge_detector_if.sv
// Pin, control and status bundle between the edge detector and the SPI master control logic.
interface multi_edge_detector_if #(
    parameter int unsigned CHANNELS = 8
);
    logic [CHANNELS-1:0]   signal;
    logic [2*CHANNELS-1:0] mode;
    logic [CHANNELS-1:0]   status_clr;
    logic [CHANNELS-1:0]   irq_en;
    logic [CHANNELS-1:0]   positive_edge;
    logic [CHANNELS-1:0]   negative_edge;
    logic [CHANNELS-1:0]   event_pulse;
    logic [CHANNELS-1:0]   status;
    logic [CHANNELS-1:0]   overrun;
    logic                  irq;

    modport master (
        output signal, mode, status_clr, irq_en,
        input  positive_edge, negative_edge, event_pulse, status, overrun, irq
    );

    modport slave (
        input  signal, mode, status_clr, irq_en,
        output positive_edge, negative_edge, event_pulse, status, overrun, irq
    );
endinterface

// File: rtl/edge_det_channel.sv
// One channel: synchroniser, optional glitch filter (EDGE_GLITCH_FILTER_EN), level register,
// edge/event pulses and sticky status/overrun.
module edge_det_channel
    import edge_det_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
`ifdef EDGE_GLITCH_FILTER_EN
    , parameter int unsigned FILTER_CYCLES = 4
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       priming,
    input  logic       pin,
    input  edge_mode_t mode,
    input  logic       status_clr,
    output logic       positive_edge,
    output logic       negative_edge,
    output logic       event_pulse,
    output logic       status,
    output logic       overrun
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   cur;
    logic                   level_q;
    logic                   rise_c;
    logic                   fall_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
    end

    assign synced = sync_q[SYNC_STAGES-1];

`ifdef EDGE_GLITCH_FILTER_EN
    localparam int unsigned CNT_W = $clog2(FILTER_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             filt_q;

    // While priming the filter adopts the synced value directly so a static pin never looks like an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else if (priming) begin
            cnt_q  <= '0;
            filt_q <= synced;
        end else if (synced == filt_q) begin
            cnt_q  <= '0;
        end else if (cnt_q == CNT_W'(FILTER_CYCLES - 1)) begin
            cnt_q  <= '0;
            filt_q <= synced;
        end else begin
            cnt_q  <= cnt_q + CNT_W'(1);
        end
    end

    assign cur = filt_q;
`else
    assign cur = synced;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) level_q <= 1'b0;
        else        level_q <= priming ? synced : cur;
    end

    assign rise_c = ~level_q & cur;
    assign fall_c = level_q & ~cur;

    // A set arriving with a clear wins for status; overrun only ever clears on status_clr.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            positive_edge <= 1'b0;
            negative_edge <= 1'b0;
            event_pulse   <= 1'b0;
            status        <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            positive_edge <= rise_c & ~priming;
            negative_edge <= fall_c & ~priming;
            event_pulse   <= ~priming & qualify(mode, rise_c, fall_c);
            status        <= event_pulse | (status & ~status_clr);
            overrun       <= ~status_clr & (overrun | (event_pulse & status));
        end
    end

endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel synchronising edge detector with sticky status and a shared interrupt.
// Optional glitch filter enabled by defining EDGE_GLITCH_FILTER_EN.
module multi_edge_detector
    import edge_det_pkg::*;
#(
    parameter int unsigned CHANNELS      = 8,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    multi_edge_detector_if.slave  bus
);

    localparam int unsigned PRIME_CYCLES = SYNC_STAGES + 1;
    localparam int unsigned PRIME_W      = $clog2(PRIME_CYCLES + 1);

    if (CHANNELS < 1 || CHANNELS > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
        FILTER_CYCLES < 1 || FILTER_CYCLES > 255) begin : g_bad_cfg
        $error("multi_edge_detector: parameter out of range");
    end

    logic [PRIME_W-1:0] prime_cnt_q;
    logic               priming;

    // Edge outputs stay quiet until the sync chain holds post-reset samples only.
    assign priming = (prime_cnt_q != PRIME_W'(PRIME_CYCLES));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       prime_cnt_q <= '0;
        else if (priming) prime_cnt_q <= prime_cnt_q + PRIME_W'(1);
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        edge_det_channel #(
            .SYNC_STAGES   (SYNC_STAGES)
`ifdef EDGE_GLITCH_FILTER_EN
            , .FILTER_CYCLES (FILTER_CYCLES)
`endif
        ) u_ch (
            .clk           (clk),
            .reset         (reset),
            .priming       (priming),
            .pin           (bus.signal[i]),
            .mode          (edge_mode_t'(bus.mode[2*i +: 2])),
            .status_clr    (bus.status_clr[i]),
            .positive_edge (bus.positive_edge[i]),
            .negative_edge (bus.negative_edge[i]),
            .event_pulse   (bus.event_pulse[i]),
            .status        (bus.status[i]),
            .overrun       (bus.overrun[i])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) bus.irq <= 1'b0;
        else        bus.irq <= |(bus.status & bus.irq_en);
    end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed scenarios plus randomized traffic checked against a pin-history reference model.
module tb_multi_edge_detector;
    import edge_det_pkg::*;

    localparam int CH = 8;
    localparam int S  = 2;
    localparam int F  = 4;
`ifdef EDGE_GLITCH_FILTER_EN
    localparam int LAT = S + F + 1;
    localparam int D   = S + 1;
`else
    localparam int LAT = S + 1;
    localparam int D   = S;
`endif
    localparam int N = 600;

    logic clk = 1'b0;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;

    multi_edge_detector_if #(.CHANNELS(CH)) bus ();

    multi_edge_detector #(
        .CHANNELS      (CH),
        .SYNC_STAGES   (S),
        .FILTER_CYCLES (F)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pos"}, 32'(bus.positive_edge), 0);
        check({tag, "_neg"}, 32'(bus.negative_edge), 0);
        check({tag, "_evt"}, 32'(bus.event_pulse), 0);
        check({tag, "_sts"}, 32'(bus.status), 0);
        check({tag, "_ovr"}, 32'(bus.overrun), 0);
        check({tag, "_irq"}, 32'(bus.irq), 0);
    endtask

    // Reference model history, indexed by clock edge since reset release.
    logic [CH-1:0] p_h   [0:N];
    logic [CH-1:0] fp_h  [0:N];
    logic [15:0]   md_h  [0:N];
    logic [CH-1:0] clr_h [0:N];
    logic [CH-1:0] en_h  [0:N];
    logic [CH-1:0] pos_m [0:N];
    logic [CH-1:0] neg_m [0:N];
    logic [CH-1:0] ev_m  [0:N];
    logic [CH-1:0] st_m  [0:N];
    logic [CH-1:0] ov_m  [0:N];
    logic          irq_m [0:N];
    logic [CH-1:0] init_v, rmask, fmask, flip;

    initial begin
        bus.signal = '0; bus.mode = 16'h5555; bus.status_clr = '0; bus.irq_en = '0;
        reset = 1'b0;

        // Reset state, then a single rising edge on ch0
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b1;
        repeat (LAT + 4) tick();
        bus.signal[0] = 1'b1;
        repeat (LAT - 1) tick();
        check("t1_pos_early", 32'(bus.positive_edge[0]), 0);
        tick();
        check("t1_pos", 32'(bus.positive_edge[0]), 1);
        check("t1_evt", 32'(bus.event_pulse[0]), 1);
        check("t1_sts_early", 32'(bus.status[0]), 0);
        tick();
        check("t1_pos_once", 32'(bus.positive_edge[0]), 0);
        check("t1_sts", 32'(bus.status[0]), 1);

        // Fall-only mode ignores a rising edge but still reports it raw
        bus.status_clr = 8'h01; bus.mode[1:0] = MODE_OFF;
        tick();
        bus.status_clr = '0;
        bus.signal[0] = 1'b0;
        repeat (LAT + 2) tick();
        check("t2_sts_cleared", 32'(bus.status[0]), 0);
        bus.mode[1:0] = MODE_FALL;
        bus.signal[0] = 1'b1;
        repeat (LAT) tick();
        check("t2_pos", 32'(bus.positive_edge[0]), 1);
        check("t2_evt", 32'(bus.event_pulse[0]), 0);
        tick();
        check("t2_sts", 32'(bus.status[0]), 0);

        // Overrun on ch3, then clear colliding with a new event
        bus.signal[3] = 1'b1;
        repeat (LAT) tick();
        check("t3_evt1", 32'(bus.event_pulse[3]), 1);
        tick();
        check("t3_sts1", 32'(bus.status[3]), 1);
        check("t3_ovr1", 32'(bus.overrun[3]), 0);
        bus.signal[3] = 1'b0;
        repeat (LAT + 1) tick();
        bus.signal[3] = 1'b1;
        repeat (LAT) tick();
        check("t3_evt2", 32'(bus.event_pulse[3]), 1);
        tick();
        check("t3_ovr2", 32'(bus.overrun[3]), 1);
        bus.signal[3] = 1'b0;
        repeat (LAT + 1) tick();
        bus.signal[3] = 1'b1;
        repeat (LAT) tick();
        check("t3_evt3", 32'(bus.event_pulse[3]), 1);
        bus.status_clr[3] = 1'b1;
        tick();
        bus.status_clr = '0;
        check("t3_sts_setwins", 32'(bus.status[3]), 1);
        check("t3_ovr_cleared", 32'(bus.overrun[3]), 0);

        // Pins high through reset produce nothing; a later drop on ch5 gives one falling pulse
        bus.mode = 16'hFFFF; bus.signal = 8'hFF; reset = 1'b0;
        tick();
        check_all_zero("t4_reset");
        reset = 1'b1;
        for (int c = 0; c < LAT + 6; c++) begin
            tick();
            check("t4_quiet", 32'({bus.positive_edge, bus.negative_edge, bus.event_pulse}), 0);
        end
        bus.signal[5] = 1'b0;
        repeat (LAT) tick();
        check("t4_neg", 32'(bus.negative_edge), 32'h20);
        check("t4_pos", 32'(bus.positive_edge), 0);
        tick();
        check("t4_neg_once", 32'(bus.negative_edge), 0);

`ifdef EDGE_GLITCH_FILTER_EN
        // Short glitch suppressed, long pulse passes after the filter delay
        bus.signal[2] = 1'b0;
        repeat (LAT + 2) tick();
        bus.signal[2] = 1'b1;
        repeat (F - 1) tick();
        bus.signal[2] = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            check("t5_glitch", 32'({bus.positive_edge[2], bus.negative_edge[2]}), 0);
        end
        bus.signal[2] = 1'b1;
        for (int c = 1; c <= LAT; c++) begin
            tick();
            check("t5_pos", 32'(bus.positive_edge[2]), (c == LAT) ? 1 : 0);
            if (c == 6) bus.signal[2] = 1'b0;
        end
`endif

        // Interrupt follows status by one cycle; async reset clears everything at once
        bus.signal = '0; bus.mode = 16'h5555;
        repeat (LAT + F + 4) tick();
        bus.status_clr = '1;
        tick();
        bus.status_clr = '0;
        bus.irq_en = 8'h01;
        tick();
        check("t6_irq_idle", 32'(bus.irq), 0);
        bus.signal[0] = 1'b1;
        repeat (LAT) tick();
        check("t6_evt", 32'(bus.event_pulse[0]), 1);
        tick();
        check("t6_sts", 32'(bus.status[0]), 1);
        check("t6_irq_early", 32'(bus.irq), 0);
        tick();
        check("t6_irq", 32'(bus.irq), 1);
        bus.mode[3:2] = MODE_BOTH;
        bus.signal[1] = 1'b1;
        repeat (LAT) tick();
        check("t6_pos1", 32'(bus.positive_edge[1]), 1);
        #1 reset = 1'b0;
        #1 check_all_zero("t6_async");

        // Randomized traffic against the reference model
        init_v = 8'($urandom);
        bus.signal = init_v; bus.mode = 16'($urandom); bus.status_clr = '0; bus.irq_en = 8'($urandom);
        p_h[0] = init_v; fp_h[0] = init_v; md_h[0] = bus.mode; clr_h[0] = '0; en_h[0] = bus.irq_en;
        pos_m[0] = '0; neg_m[0] = '0; ev_m[0] = '0; st_m[0] = '0; ov_m[0] = '0; irq_m[0] = 1'b0;
        tick();
        reset = 1'b1;
        for (int t = 1; t <= N; t++) begin
            int a, b;
            flip = 8'($urandom) & 8'($urandom);
            p_h[t]   = (t <= 12) ? init_v : (p_h[t-1] ^ flip);
            md_h[t]  = (t % 16 == 0) ? 16'($urandom) : md_h[t-1];
            clr_h[t] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
            en_h[t]  = (t % 32 == 0) ? 8'($urandom) : en_h[t-1];
            bus.signal = p_h[t]; bus.mode = md_h[t]; bus.status_clr = clr_h[t]; bus.irq_en = en_h[t];

            // Filtered pin flips once the last F samples all disagree with it
            fp_h[t] = p_h[t];
`ifdef EDGE_GLITCH_FILTER_EN
            fp_h[t] = fp_h[t-1];
            for (int c = 0; c < CH; c++) begin
                logic all_diff;
                all_diff = (t >= F);
                for (int k = 0; k < F; k++)
                    if (t - k >= 0 && p_h[t-k][c] == fp_h[t-1][c]) all_diff = 1'b0;
                if (all_diff) fp_h[t][c] = ~fp_h[t-1][c];
            end
`endif
            a = (t > D) ? t - D : 0;
            b = (t > D + 1) ? t - D - 1 : 0;
            pos_m[t] = fp_h[a] & ~fp_h[b];
            neg_m[t] = ~fp_h[a] & fp_h[b];
            for (int c = 0; c < CH; c++) begin
                rmask[c] = md_h[t][2*c];
                fmask[c] = md_h[t][2*c+1];
            end
            ev_m[t]  = (pos_m[t] & rmask) | (neg_m[t] & fmask);
            st_m[t]  = ev_m[t-1] | (st_m[t-1] & ~clr_h[t]);
            ov_m[t]  = ~clr_h[t] & (ov_m[t-1] | (ev_m[t-1] & st_m[t-1]));
            irq_m[t] = |(st_m[t-1] & en_h[t]);

            tick();
            check("rnd_pos", 32'(bus.positive_edge), 32'(pos_m[t]));
            check("rnd_neg", 32'(bus.negative_edge), 32'(neg_m[t]));
            check("rnd_evt", 32'(bus.event_pulse), 32'(ev_m[t]));
            check("rnd_sts", 32'(bus.status), 32'(st_m[t]));
            check("rnd_ovr", 32'(bus.overrun), 32'(ov_m[t]));
            check("rnd_irq", 32'(bus.irq), 32'(irq_m[t]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
